// File: rtl/microcode_sequencer.sv
// microcode_sequencer
//
// Generates the 9-bit microcode address that feeds the microcode ROM.
// It fetches opcode bytes, turns a 0xCB prefix into bit 8 of the address,
// follows link fields fed back from the control word, handles HALT, and
// injects the interrupt-entry routine at instruction boundaries.
//
// Parameters:
//   IRQ_ENTRY_ADDR - microcode address of the interrupt-entry routine
//   MAX_STEPS      - watchdog step limit (only used with UC_STEP_WATCHDOG_EN)
//
// Optional feature macro: UC_STEP_WATCHDOG_EN
//   When defined, a watchdog counts EXEC steps of the current instruction.
//   If MAX_STEPS steps pass without a last step, it pulses wd_fault and
//   forces the sequencer back to FETCH. When undefined, wd_fault is tied to 0.
//
// Ports:
//   clk         - system clock
//   rst         - synchronous reset, active-high
//   mem_data    - opcode byte returned by the bus
//   mem_ready   - mem_data valid this cycle
//   fetch_req   - request an opcode-byte read at PC (high in FETCH)
//   uc_next     - control-word field: next microcode address
//   uc_last     - control-word bit: this step ends the instruction
//   uc_wait     - control-word bit: hold this step until mem_ready
//   uc_cond     - control-word bit: conditional step
//   cond_met    - ALU flag condition result for uc_cond
//   uc_halt     - control-word bit: enter HALT after this step
//   irq_pending - enabled interrupt pending
//   ime         - interrupt master enable
//   uc_addr     - registered microcode address to the ROM
//   cb_mode     - current instruction is CB-prefixed
//   halted      - sequencer is in HALT
//   step_cnt    - steps executed in the current instruction, saturating at 15
//   wd_fault    - watchdog fault pulse

module microcode_sequencer #(
    parameter logic [8:0] IRQ_ENTRY_ADDR = 9'h1FF,
    parameter int         MAX_STEPS      = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] mem_data,
    input  logic       mem_ready,
    output logic       fetch_req,
    input  logic [8:0] uc_next,
    input  logic       uc_last,
    input  logic       uc_wait,
    input  logic       uc_cond,
    input  logic       cond_met,
    input  logic       uc_halt,
    input  logic       irq_pending,
    input  logic       ime,
    output logic [8:0] uc_addr,
    output logic       cb_mode,
    output logic       halted,
    output logic [3:0] step_cnt,
    output logic       wd_fault
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t state;

    // A failed conditional behaves exactly like the last step of the
    // instruction; a wait step with no bus data freezes everything.
    logic end_step;
    logic stalled;

    assign end_step  = uc_last | (uc_cond & ~cond_met);
    assign stalled   = uc_wait & ~mem_ready;
    assign fetch_req = (state == FETCH);

`ifdef UC_STEP_WATCHDOG_EN
    localparam int WD_W = $clog2(MAX_STEPS + 1);

    logic [WD_W-1:0] wd_cnt;
    logic            wd_trip;

    // Trips on the advancing step that would be the MAX_STEPS-th one
    // without the instruction having ended.
    assign wd_trip = (state == EXEC) && !stalled && !end_step &&
                     (wd_cnt == WD_W'(MAX_STEPS - 1));
`else
    assign wd_fault = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FETCH;
            uc_addr  <= 9'h000;
            cb_mode  <= 1'b0;
            halted   <= 1'b0;
            step_cnt <= 4'd0;
`ifdef UC_STEP_WATCHDOG_EN
            wd_cnt   <= '0;
            wd_fault <= 1'b0;
`endif
        end else begin
`ifdef UC_STEP_WATCHDOG_EN
            wd_fault <= 1'b0;
`endif
            case (state)
                FETCH: begin
                    if (mem_ready) begin
                        // The prefix is only recognised as the first byte;
                        // a second 0xCB is an ordinary CB-page opcode.
                        if (mem_data == 8'hCB && !cb_mode) begin
                            cb_mode <= 1'b1;
                        end else begin
                            uc_addr  <= {cb_mode, mem_data};
                            step_cnt <= 4'd0;
`ifdef UC_STEP_WATCHDOG_EN
                            wd_cnt   <= '0;
`endif
                            state    <= EXEC;
                        end
                    end
                end

                EXEC: begin
                    if (!stalled) begin
                        if (end_step) begin
                            // The instruction is over on every path here,
                            // so the prefix flag no longer applies.
                            cb_mode <= 1'b0;
                            if (uc_halt) begin
                                state   <= HALT;
                                halted  <= 1'b1;
                                uc_addr <= 9'h000;
                            end else if (irq_pending && ime) begin
                                uc_addr  <= IRQ_ENTRY_ADDR;
                                step_cnt <= 4'd0;
`ifdef UC_STEP_WATCHDOG_EN
                                wd_cnt   <= '0;
`endif
                            end else begin
                                state <= FETCH;
                            end
                        end else begin
                            uc_addr  <= uc_next;
                            step_cnt <= (step_cnt == 4'd15) ? 4'd15 : step_cnt + 4'd1;
`ifdef UC_STEP_WATCHDOG_EN
                            wd_cnt   <= wd_cnt + WD_W'(1);
                            if (wd_trip) begin
                                wd_fault <= 1'b1;
                                state    <= FETCH;
                                cb_mode  <= 1'b0;
                                uc_addr  <= 9'h000;
                                wd_cnt   <= '0;
                            end
`endif
                        end
                    end
                end

                HALT: begin
                    // Any pending interrupt wakes the core; ime only
                    // decides whether the entry routine is taken.
                    if (irq_pending) begin
                        halted <= 1'b0;
                        if (ime) begin
                            state    <= EXEC;
                            uc_addr  <= IRQ_ENTRY_ADDR;
                            step_cnt <= 4'd0;
`ifdef UC_STEP_WATCHDOG_EN
                            wd_cnt   <= '0;
`endif
                        end else begin
                            state <= FETCH;
                        end
                    end
                end

                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_microcode_sequencer.sv
// tb_microcode_sequencer
//
// Self-checking bench for microcode_sequencer. A behavioural reference model
// tracks what the sequencer should be doing (fetching, executing, halted)
// and the expected outputs; directed scenarios are followed by randomized
// stimulus, and every cycle the DUT outputs are compared with the model.

module tb_microcode_sequencer;

    logic       clk;
    logic       rst;
    logic [7:0] mem_data;
    logic       mem_ready;
    logic       fetch_req;
    logic [8:0] uc_next;
    logic       uc_last;
    logic       uc_wait;
    logic       uc_cond;
    logic       cond_met;
    logic       uc_halt;
    logic       irq_pending;
    logic       ime;
    logic [8:0] uc_addr;
    logic       cb_mode;
    logic       halted;
    logic [3:0] step_cnt;
    logic       wd_fault;

    int checks   = 0;
    int failures = 0;

    microcode_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .mem_data   (mem_data),
        .mem_ready  (mem_ready),
        .fetch_req  (fetch_req),
        .uc_next    (uc_next),
        .uc_last    (uc_last),
        .uc_wait    (uc_wait),
        .uc_cond    (uc_cond),
        .cond_met   (cond_met),
        .uc_halt    (uc_halt),
        .irq_pending(irq_pending),
        .ime        (ime),
        .uc_addr    (uc_addr),
        .cb_mode    (cb_mode),
        .halted     (halted),
        .step_cnt   (step_cnt),
        .wd_fault   (wd_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: what the core is doing and the outputs it should show.
    string      m_doing;
    logic [8:0] m_addr;
    logic       m_cb;
    int         m_steps;

    task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance the reference model by one clock given this cycle's inputs.
    task automatic modelStep();
        if (rst) begin
            m_doing = "fetch";
            m_addr  = 9'h000;
            m_cb    = 1'b0;
            m_steps = 0;
        end else if (m_doing == "fetch") begin
            if (mem_ready) begin
                if (mem_data == 8'hCB && !m_cb) begin
                    m_cb = 1'b1;
                end else begin
                    m_addr  = {m_cb, mem_data};
                    m_steps = 0;
                    m_doing = "exec";
                end
            end
        end else if (m_doing == "exec") begin
            if (uc_wait && !mem_ready) begin
                // frozen
            end else if (uc_last || (uc_cond && !cond_met)) begin
                m_cb = 1'b0;
                if (uc_halt) begin
                    m_doing = "halt";
                    m_addr  = 9'h000;
                end else if (irq_pending && ime) begin
                    m_addr  = 9'h1FF;
                    m_steps = 0;
                end else begin
                    m_doing = "fetch";
                end
            end else begin
                m_addr  = uc_next;
                m_steps = (m_steps + 1 > 15) ? 15 : m_steps + 1;
            end
        end else begin
            if (irq_pending) begin
                if (ime) begin
                    m_doing = "exec";
                    m_addr  = 9'h1FF;
                    m_steps = 0;
                end else begin
                    m_doing = "fetch";
                end
            end
        end
    endtask

    // Drive one cycle of inputs, clock it, then compare every output.
    task automatic applyStimulus(input logic r, input logic mr, input logic [7:0] md,
                                 input logic [8:0] nx, input logic last, input logic wt,
                                 input logic cnd, input logic cm, input logic hlt,
                                 input logic irq, input logic ie);
        rst = r; mem_ready = mr; mem_data = md; uc_next = nx; uc_last = last;
        uc_wait = wt; uc_cond = cnd; cond_met = cm; uc_halt = hlt;
        irq_pending = irq; ime = ie;
        modelStep();
        @(posedge clk);
        #1;
        checkOutput("uc_addr",   16'(uc_addr),   16'(m_addr));
        checkOutput("cb_mode",   16'(cb_mode),   16'(m_cb));
        checkOutput("halted",    16'(halted),    16'(m_doing == "halt"));
        checkOutput("fetch_req", 16'(fetch_req), 16'(m_doing == "fetch"));
        checkOutput("step_cnt",  16'(step_cnt),  16'(m_steps));
        checkOutput("wd_fault",  16'(wd_fault),  16'h0);
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 1'b0, 8'h00, 9'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic fetchByte(input logic [7:0] b);
        applyStimulus(1'b0, 1'b1, b, 9'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic execStep(input logic [8:0] nx, input logic last, input logic hlt,
                            input logic irq, input logic ie);
        applyStimulus(1'b0, 1'b0, 8'h00, nx, last, 1'b0, 1'b0, 1'b0, hlt, irq, ie);
    endtask

    initial begin
        doReset();
        checkOutput("reset_addr", 16'(uc_addr), 16'h000);
        checkOutput("reset_fetch_req", 16'(fetch_req), 16'h1);

        // Plain opcode fetch
        fetchByte(8'h3E);
        checkOutput("op3e_addr", 16'(uc_addr), 16'h03E);
        checkOutput("op3e_fetch_req", 16'(fetch_req), 16'h0);
        execStep(9'h000, 1'b1, 1'b0, 1'b0, 1'b0);

        // CB prefix, including 0xCB as the second byte
        fetchByte(8'hCB);
        checkOutput("cb_after_prefix", 16'(cb_mode), 16'h1);
        fetchByte(8'h11);
        checkOutput("cb11_addr", 16'(uc_addr), 16'h111);
        execStep(9'h000, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("cb_cleared", 16'(cb_mode), 16'h0);
        fetchByte(8'hCB);
        fetchByte(8'hCB);
        checkOutput("cbcb_addr", 16'(uc_addr), 16'h1CB);
        execStep(9'h000, 1'b1, 1'b0, 1'b0, 1'b0);

        // Linked steps
        fetchByte(8'h40);
        execStep(9'h150, 1'b0, 1'b0, 1'b0, 1'b0);
        execStep(9'h151, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("link_addr", 16'(uc_addr), 16'h151);
        checkOutput("link_steps", 16'(step_cnt), 16'h2);
        execStep(9'h0AA, 1'b1, 1'b0, 1'b0, 1'b0);

        // Conditional step not taken ends the instruction
        fetchByte(8'h20);
        applyStimulus(1'b0, 1'b0, 8'h00, 9'h077, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("cond_fetch", 16'(fetch_req), 16'h1);

        // Wait step with no bus data for three cycles
        fetchByte(8'h0A);
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b0, 1'b0, 8'h00, 9'h123, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("wait_frozen", 16'(uc_addr), 16'h00A);
        applyStimulus(1'b0, 1'b1, 8'h00, 9'h123, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("wait_advance", 16'(uc_addr), 16'h123);
        execStep(9'h000, 1'b1, 1'b0, 1'b0, 1'b0);

        // HALT, wake with ime=1 into the interrupt routine
        fetchByte(8'h76);
        execStep(9'h000, 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("halt_set", 16'(halted), 16'h1);
        execStep(9'h000, 1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("irq_entry", 16'(uc_addr), 16'h1FF);
        checkOutput("halt_clear", 16'(halted), 16'h0);
        execStep(9'h000, 1'b1, 1'b0, 1'b0, 1'b0);

        // HALT and IRQ together, ime=0: HALT first, then straight to FETCH
        fetchByte(8'h76);
        execStep(9'h000, 1'b1, 1'b1, 1'b1, 1'b0);
        checkOutput("halt_prio", 16'(halted), 16'h1);
        execStep(9'h000, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("wake_fetch", 16'(fetch_req), 16'h1);

        // Back-to-back interrupt entry from a last step
        fetchByte(8'h00);
        execStep(9'h000, 1'b1, 1'b0, 1'b1, 1'b1);
        checkOutput("irq_boundary", 16'(uc_addr), 16'h1FF);
        execStep(9'h000, 1'b1, 1'b0, 1'b0, 1'b0);

        // Step counter saturation over a long instruction
        fetchByte(8'h55);
        for (int i = 0; i < 18; i++)
            execStep(9'(9'h100 + i), 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("step_sat", 16'(step_cnt), 16'hF);
        execStep(9'h000, 1'b1, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of an instruction
        fetchByte(8'hCB);
        fetchByte(8'h40);
        execStep(9'h151, 1'b0, 1'b0, 1'b0, 1'b0);
        doReset();
        checkOutput("midreset_addr", 16'(uc_addr), 16'h000);
        checkOutput("midreset_cb", 16'(cb_mode), 16'h0);

        // Randomized traffic against the model
        for (int i = 0; i < 2000; i++) begin
            applyStimulus(($urandom_range(0, 99) == 0),
                          ($urandom_range(0, 9) < 6),
                          ($urandom_range(0, 3) == 0) ? 8'hCB : 8'($urandom),
                          9'($urandom),
                          ($urandom_range(0, 3) == 0),
                          ($urandom_range(0, 4) == 0),
                          ($urandom_range(0, 4) == 0),
                          1'($urandom),
                          ($urandom_range(0, 7) == 0),
                          ($urandom_range(0, 5) == 0),
                          1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/microcode_sequencer.md
Name: microcode_sequencer

Overview:
- Upstream neighbour of the microcode ROM stage: generates the 9-bit microcode address (`uc_addr`) that the ROM turns into the 64-bit control word each cycle.
- Fetches opcode bytes and handles the 0xCB prefix as bit 8 of the address.
- Follows link fields fed back from the control word, handles HALT, and injects the interrupt-entry routine at instruction boundaries.

Parameters:
- IRQ_ENTRY_ADDR, 9'h1FF, microcode address of the interrupt-entry routine.
- MAX_STEPS, 16, watchdog step limit (used only with the optional feature).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- mem_data  input  8  opcode byte returned by the bus
- mem_ready  input  1  mem_data valid this cycle
- fetch_req  output  1  request an opcode-byte read at PC
- uc_next  input  9  control-word field: next microcode address
- uc_last  input  1  control-word bit: this step ends the instruction
- uc_wait  input  1  control-word bit: hold this step until mem_ready
- uc_cond  input  1  control-word bit: conditional step
- cond_met  input  1  ALU flag condition result for uc_cond
- uc_halt  input  1  control-word bit: enter HALT after this step
- irq_pending  input  1  enabled interrupt pending
- ime  input  1  interrupt master enable
- uc_addr  output  9  registered microcode address to the ROM
- cb_mode  output  1  current instruction is CB-prefixed
- halted  output  1  sequencer is in HALT
- step_cnt  output  4  steps executed in the current instruction, saturating at 15
- wd_fault  output  1  watchdog fault pulse (0 when the feature is compiled out)

Behaviour:
- States: FETCH, EXEC, HALT. All outputs are registered.
- Reset (rst=1 at a clk edge), from any state including mid-instruction:
  - state=FETCH, uc_addr=9'h000 (NOP entry), cb_mode=0, halted=0, step_cnt=0, wd_fault=0.
  - fetch_req is combinational on state=FETCH, so it reads 1 in the first cycle after reset.
- FETCH:
  - fetch_req=1; uc_addr holds its previous value.
  - On mem_ready with mem_data==8'hCB and cb_mode=0: set cb_mode=1, stay in FETCH. The prefix byte is consumed and the next byte is fetched.
  - On mem_ready otherwise: uc_addr={cb_mode, mem_data}, step_cnt=0, go to EXEC next cycle. Latency is one clk from mem_ready to the new uc_addr.
- EXEC: uc_addr is presented to the ROM and the control-word inputs are sampled in the same cycle. Priority per cycle:
  1. uc_wait=1 and mem_ready=0: hold everything.
  2. uc_cond=1 and cond_met=0: treat as uc_last (branch not taken).
  3. uc_last=1:
     - If uc_halt=1: go to HALT.
     - Else if irq_pending and ime: uc_addr=IRQ_ENTRY_ADDR, cb_mode=0, step_cnt=0, stay in EXEC.
     - Else: cb_mode=0, go to FETCH.
  4. Otherwise: uc_addr=uc_next, step_cnt += 1 (saturating at 15).
- Interrupt-routine termination: the routine ends like any instruction. Its last step returns to FETCH unless another IRQ qualifies, in which case it re-enters IRQ_ENTRY_ADDR.
- HALT:
  - halted=1, fetch_req=0, uc_addr=9'h000.
  - On irq_pending, regardless of ime:
    - ime=1: go to EXEC at IRQ_ENTRY_ADDR.
    - ime=0: go to FETCH.
  - halted clears in the same transition.
- Simultaneous uc_halt and irq_pending on the last step: HALT has priority. HALT then exits on the following cycle because irq_pending is still high.
- uc_next is ignored on a last step. The CB prefix is never recognised in the second FETCH byte (0xCB after the prefix maps to 9'h1CB).

Optional Feature:
- Macro: UC_STEP_WATCHDOG_EN.
- Defined:
  - Counts EXEC steps in a watchdog counter wide enough for MAX_STEPS; the counter is separate from the saturating step_cnt.
  - On reaching MAX_STEPS without uc_last: wd_fault pulses 1 for one cycle, state is forced to FETCH, cb_mode=0, uc_addr=9'h000.
- Not defined: no counter is built and wd_fault is tied to 0.

Test Plan:
- Reset, then mem_ready with mem_data=8'h3E -> uc_addr=9'h03E one cycle later; fetch_req=0 in EXEC.
- CB prefix: bytes 8'hCB then 8'h11 -> cb_mode=1 after the first byte; uc_addr=9'h111; cb_mode=0 after uc_last.
- Linked steps: uc_next=9'h150 then 9'h151 with uc_last on the third step -> uc_addr sequence 0xXX, 0x150, 0x151, then FETCH; step_cnt=2 on the final step.
- Conditional not taken: uc_cond=1, cond_met=0 -> FETCH next cycle; uc_next ignored.
- uc_wait=1 with mem_ready low for 3 cycles -> uc_addr frozen for 3 cycles, then advances.
- HALT/IRQ: uc_halt on the last step -> halted=1. Then irq_pending=1 with ime=1 -> uc_addr=9'h1FF and halted=0 next cycle. With ime=0 -> FETCH instead.
- Reset asserted mid-EXEC at uc_addr=9'h151 -> the next cycle shows FETCH, uc_addr=0, cb_mode=0. With UC_STEP_WATCHDOG_EN and uc_last held low for 16 steps -> wd_fault pulses and the sequencer enters FETCH.
